uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_select2.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default data-width / start-timeout constants reused by the UART and top blocks.
package uart_tx_arbiter_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_START_TO = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_select2.sv
// Two-requester round-robin selector: a one-hot grant from the valid flags,
// the priority pointer, and the current packet lock/owner.
module rr_select2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       lock,
  input  logic       owner,
  output logic [1:0] grant
);

  // A held lock only ever grants the owner, even if it is currently idle
  always_comb begin
    grant = 2'b00;
    if (lock) begin
      grant[owner] = valid[owner];
    end else if (valid == 2'b11) begin
      grant[ptr] = 1'b1;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte sources onto one UART transmitter with round-robin
// priority, packet lock, a one-cycle start pulse and a sticky start-timeout flag.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int START_TO = DEF_START_TO
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_lock,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              grant_id,
  output logic              arb_busy,
  output logic              err_to,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(START_TO + 1);

  arb_state_t       state, state_nxt;
  logic             ptr;
  logic             lock_q;
  logic [CNT_W-1:0] to_cnt;
  logic [1:0]       grant;
  logic             accept;
  logic             sel_id;
  logic             timeout;

  rr_select2 u_sel (
    .valid (req_valid),
    .ptr   (ptr),
    .lock  (lock_q),
    .owner (grant_id),
    .grant (grant)
  );

  // Ready is gated by reset so nothing is offered while the block is held
  always_comb begin
    req_ready = 2'b00;
    if (sys_rst && state == IDLE && !tx_busy) begin
      req_ready = grant;
    end
    accept   = |(req_valid & req_ready);
    sel_id   = req_ready[1];
    timeout  = (state == WAIT_BUSY) && !tx_busy && (to_cnt == CNT_W'(START_TO - 1));
    tx_start = (state == START);
    arb_busy = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // to_cnt equals the number of cycles elapsed since the tx_start cycle
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      tx_data  <= '0;
      grant_id <= 1'b0;
      ptr      <= 1'b0;
      lock_q   <= 1'b0;
      to_cnt   <= '0;
      err_to   <= 1'b0;
    end else begin
      if (accept) begin
        tx_data  <= sel_id ? req_data1 : req_data0;
        grant_id <= sel_id;
        lock_q   <= req_lock[sel_id];
        if (!req_lock[sel_id]) begin
          ptr <= ~sel_id;
        end
      end else if (timeout) begin
        lock_q <= 1'b0;
      end

      if (state == START) begin
        to_cnt <= CNT_W'(1);
      end else if (state == WAIT_BUSY) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end else begin
        to_cnt <= '0;
      end

      if (timeout) begin
        err_to <= 1'b1;
      end else if (err_clr) begin
        err_to <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter
// model and a monitor that logs every started byte as {grant_id, tx_data}.
module tb_uart_tx_arbiter;

  logic       sys_clk;
  logic       sys_rst;
  logic [1:0] req_valid;
  logic [1:0] req_lock;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       grant_id;
  logic       arb_busy;
  logic       err_to;
  logic       err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  // transmitter model controls
  bit tx_en     = 1'b1;
  bit hold_busy = 1'b0;
  int busy_len  = 10;
  int busy_left = 0;

  // monitor state
  int         cyc            = 0;
  int         last_start_cyc = -1000;
  int         err_rise_cyc   = -2000;
  logic       err_prev       = 1'b0;
  logic [8:0] sent_q[$];

  // requester queues, element = {lock, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  uart_tx_arbiter #(.DATA_W(8), .START_TO(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .err_to    (err_to),
    .err_clr   (err_clr)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Transmitter: busy rises with the start pulse and lasts busy_len cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_en && tx_start) begin
        busy_left = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      tx_busy = hold_busy || (busy_left > 0);
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (tx_start) begin
        sent_q.push_back({grant_id, tx_data});
        last_start_cyc = cyc;
      end
      if (err_to && !err_prev) err_rise_cyc = cyc;
      err_prev = err_to;
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkSent(input string tag, input int idx, input logic [8:0] exp);
    if (idx < sent_q.size()) checkOutput(tag, 32'(sent_q[idx]), 32'(exp));
    else                     checkOutput(tag, 32'hFFFF_FFFF, 32'(exp));
  endtask

  // Drives both requesters from their queues for up to 'cycles' cycles,
  // stopping early once both queues are drained and the arbiter is idle
  task automatic applyStimulus(input int cycles);
    logic [1:0] acc;
    acc = 2'b00;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (acc[0]) q0.delete(0);
      if (acc[1]) q1.delete(0);
      req_valid = {q1.size() > 0, q0.size() > 0};
      req_data0 = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      req_lock[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
      req_data1 = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      req_lock[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
      #1;
      acc = req_valid & req_ready;
      if (q0.size() == 0 && q1.size() == 0 && !arb_busy) break;
    end
    req_valid = 2'b00;
    req_lock  = 2'b00;
  endtask

  initial begin
    int n;
    int base;
    sys_rst   = 1'b0;
    req_valid = 2'b11;
    req_lock  = 2'b00;
    req_data0 = 8'hA5;
    req_data1 = 8'h5A;
    err_clr   = 1'b0;

    // reset values, with both requesters asserting valid
    tick();
    checkOutput("rst_tx_start", 32'(tx_start), 0);
    checkOutput("rst_tx_data", 32'(tx_data), 0);
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    checkOutput("rst_grant_id", 32'(grant_id), 0);
    checkOutput("rst_arb_busy", 32'(arb_busy), 0);
    checkOutput("rst_err_to", 32'(err_to), 0);
    req_valid = 2'b00;
    tick();
    sys_rst = 1'b1;
    tick();

    // single request from requester 0
    req_data0 = 8'h41;
    req_valid = 2'b01;
    #1;
    checkOutput("single_ready", 32'(req_ready), 32'b01);
    tick();
    checkOutput("single_start", 32'(tx_start), 1);
    checkOutput("single_data", 32'(tx_data), 32'h41);
    checkOutput("single_grant", 32'(grant_id), 0);
    checkOutput("single_ready_off", 32'(req_ready), 0);
    req_valid = 2'b00;
    tick();
    checkOutput("single_start_1cyc", 32'(tx_start), 0);
    n = 1;
    while (arb_busy && n < 40) begin
      tick();
      n++;
    end
    checkOutput("single_idle_latency", 32'(n), 11);
    checkOutput("single_busy_low", 32'(tx_busy), 0);
    checkOutput("single_data_hold", 32'(tx_data), 32'h41);
    checkSent("single_log", 0, {1'b0, 8'h41});

    // lone requester 1 byte moves the pointer back to requester 0
    q1.push_back({1'b0, 8'h5A});
    applyStimulus(100);
    checkSent("ptr_fix", 1, {1'b1, 8'h5A});

    // contention: pointer at 0, then requester 0 re-contends with pointer at 1
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b0, 8'h33});
    q1.push_back({1'b0, 8'h22});
    applyStimulus(200);
    checkSent("cont_first", 2, {1'b0, 8'h11});
    checkSent("cont_second", 3, {1'b1, 8'h22});
    checkSent("cont_third", 4, {1'b0, 8'h33});

    // packet lock: requester 1 keeps the grant for three bytes
    q1.push_back({1'b1, 8'hA1});
    q1.push_back({1'b1, 8'hA2});
    q1.push_back({1'b0, 8'hA3});
    q0.push_back({1'b0, 8'hB0});
    applyStimulus(300);
    checkSent("lock_b1", 5, {1'b1, 8'hA1});
    checkSent("lock_b2", 6, {1'b1, 8'hA2});
    checkSent("lock_b3", 7, {1'b1, 8'hA3});
    checkSent("lock_other", 8, {1'b0, 8'hB0});

    // locked owner drops valid: requester 0 must stay blocked
    q1.push_back({1'b1, 8'hC1});
    applyStimulus(100);
    checkSent("lockdrop_c1", 9, {1'b1, 8'hC1});
    q0.push_back({1'b0, 8'hD0});
    applyStimulus(30);
    checkOutput("lockdrop_blocked", 32'(sent_q.size()), 10);
    checkOutput("lockdrop_pending", 32'(q0.size()), 1);
    q1.push_back({1'b0, 8'hC2});
    applyStimulus(200);
    checkSent("lockdrop_c2", 10, {1'b1, 8'hC2});
    checkSent("lockdrop_d0", 11, {1'b0, 8'hD0});

    // transmitter already busy in IDLE: nothing accepted until it falls
    hold_busy = 1'b1;
    tick();
    q0.push_back({1'b0, 8'h77});
    applyStimulus(20);
    checkOutput("busyidle_blocked", 32'(sent_q.size()), 12);
    hold_busy = 1'b0;
    applyStimulus(100);
    checkSent("busyidle_sent", 12, {1'b0, 8'h77});

    // start timeout with the transmitter never responding
    tx_en = 1'b0;
    q0.push_back({1'b0, 8'h5E});
    applyStimulus(100);
    checkSent("to_sent", 13, {1'b0, 8'h5E});
    checkOutput("to_delay", 32'(err_rise_cyc - last_start_cyc), 16);
    checkOutput("to_err_set", 32'(err_to), 1);
    checkOutput("to_idle", 32'(arb_busy), 0);
    err_clr = 1'b1;
    tick();
    checkOutput("to_err_clr", 32'(err_to), 0);

    // timeout while err_clr is held high: the timeout wins
    q1.push_back({1'b0, 8'h6F});
    applyStimulus(100);
    checkSent("to2_sent", 14, {1'b1, 8'h6F});
    checkOutput("to2_delay", 32'(err_rise_cyc - last_start_cyc), 16);
    checkOutput("to2_err_wins", 32'(err_to), 1);
    tick();
    checkOutput("to2_err_clr", 32'(err_to), 0);
    err_clr = 1'b0;
    tx_en   = 1'b1;

    // reset during WAIT_DONE abandons the transfer
    q1.push_back({1'b0, 8'h99});
    applyStimulus(5);
    checkOutput("rst2_in_transfer", 32'(arb_busy), 1);
    checkSent("rst2_sent", 15, {1'b1, 8'h99});
    sys_rst = 1'b0;
    #1;
    checkOutput("rst2_tx_data", 32'(tx_data), 0);
    checkOutput("rst2_grant_id", 32'(grant_id), 0);
    checkOutput("rst2_arb_busy", 32'(arb_busy), 0);
    checkOutput("rst2_tx_start", 32'(tx_start), 0);
    checkOutput("rst2_req_ready", 32'(req_ready), 0);
    for (int i = 0; i < 3; i++) tick();
    sys_rst = 1'b1;
    base = sent_q.size();
    for (int i = 0; i < 30; i++) tick();
    checkOutput("rst2_no_restart", 32'(sent_q.size()), 32'(base));
    checkOutput("rst2_idle", 32'(arb_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
